// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: op codes, ALU state
// encodings, sequencer FSM states and the queued command record.
package alu_pkg;

    localparam int unsigned OP_W   = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RES_W  = 16;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'b000,
        ST_ADD  = 3'b001,
        ST_SUB  = 3'b010,
        ST_MUL  = 3'b011,
        ST_DIV  = 3'b100,
        ST_OUT  = 3'b101
    } alu_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } seq_state_e;

    // One queued command: op + two signed operands, 18 bits total.
    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO (op+a+b) with full/empty flags. The full flag is
// derived from registered pointers only, so a pop never frees space for a
// push in the same cycle.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  logic pop_i,
    input  cmd_t wdata_i,
    output cmd_t rdata_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    cmd_t        mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer advance on accepted push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    // Pointer registers; reset empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write; contents are don't-care until pointed at.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/alu_sequencer.sv
// Command-side initiator for the ALU: queues commands, issues one at a time,
// captures the result on the first WAIT cycle the ALU is back in IDLE, and
// returns it over a valid/ready result port.
// Optional watchdog on the WAIT state: define ALU_SEQ_TIMEOUT_EN.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned CMD_DEPTH      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic [1:0]  res_op,
    output logic        res_err,
    output logic        alu_start,
    output logic [1:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [15:0] alu_result,
    input  logic [2:0]  alu_state
);

    cmd_t        fifo_wdata, fifo_rdata;
    logic        fifo_full, fifo_empty, fifo_pop;

    seq_state_e  state_q, state_d;
    logic [1:0]  alu_op_q, alu_op_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic        res_valid_q, res_valid_d;
    logic [15:0] res_data_q, res_data_d;
    logic [1:0]  res_op_q, res_op_d;
    logic        alu_idle;

    assign fifo_wdata = '{op: cmd_op, a: cmd_a, b: cmd_b};
    assign cmd_ready  = !fifo_full;
    assign alu_idle   = (alu_state == ST_IDLE);

    alu_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid),
        .pop_i   (fifo_pop),
        .wdata_i (fifo_wdata),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            res_err_q, res_err_d;
    logic            wd_expire;
    assign wd_expire = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`endif

    // Next-state, operand load and result capture.
    always_comb begin
        state_d     = state_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_op_d    = res_op_q;
        fifo_pop    = 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
        wd_d        = '0;
        res_err_d   = res_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty && alu_idle) begin
                    fifo_pop = 1'b1;
                    alu_op_d = fifo_rdata.op;
                    alu_a_d  = fifo_rdata.a;
                    alu_b_d  = fifo_rdata.b;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (alu_idle) begin
                    res_data_d  = alu_result;
                    res_op_d    = alu_op_q;
                    res_valid_d = 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
                    res_err_d   = 1'b0;
`endif
                    state_d     = S_RESP;
                end
`ifdef ALU_SEQ_TIMEOUT_EN
                else if (wd_expire) begin
                    res_data_d  = '0;
                    res_op_d    = alu_op_q;
                    res_valid_d = 1'b1;
                    res_err_d   = 1'b1;
                    state_d     = S_RESP;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM, operand and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_op_q    <= '0;
        end else begin
            state_q     <= state_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_op_q    <= res_op_d;
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    // Watchdog counter and error flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_q      <= '0;
            res_err_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            res_err_q <= res_err_d;
        end
    end
    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    assign alu_start = (state_q == S_ISSUE);
    assign alu_op    = alu_op_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_op    = res_op_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a cycle-level ALU stand-in.
// ADD/SUB return to IDLE one cycle after leaving it; MUL/DIV spend two
// cycles in their op state plus one in OUT. The result is valid only in the
// first IDLE cycle after completion.
module tb_alu_sequencer;

    localparam int unsigned CMD_DEPTH      = 4;
    localparam int unsigned TIMEOUT_CYCLES = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a, cmd_b;
    logic        res_valid, res_ready;
    logic [15:0] res_data;
    logic [1:0]  res_op;
    logic        res_err;
    logic        alu_start;
    logic [1:0]  alu_op;
    logic [7:0]  alu_a, alu_b;
    logic [15:0] alu_result;
    logic [2:0]  alu_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    alu_sequencer #(.CMD_DEPTH(CMD_DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_op(res_op), .res_err(res_err),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_state(alu_state)
    );

    // ---------------- ALU stand-in ----------------
    logic [2:0]  stub_st;
    logic [15:0] stub_res;
    logic        stub_fresh;
    logic [1:0]  stub_cnt;
    logic        stub_stuck = 1'b0;

    assign alu_state  = stub_stuck ? 3'b011 : stub_st;
    assign alu_result = stub_res;

    function automatic logic [15:0] alu_calc(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        case (op)
            2'b00:   return sa + sb;
            2'b01:   return sa - sb;
            2'b10:   return sa * sb;
            default: return (b == 8'd0) ? 16'hFFFF : sa / sb;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stub_st <= 3'b000; stub_res <= 16'h0000; stub_fresh <= 1'b0; stub_cnt <= 2'd0;
        end else begin
            case (stub_st)
                3'b000: begin
                    if (stub_fresh) begin stub_res <= 16'h0000; stub_fresh <= 1'b0; end
                    if (alu_start) begin
                        stub_cnt <= 2'd0;
                        stub_st  <= {1'b0, alu_op} + 3'd1;
                    end
                end
                3'b001, 3'b010: begin
                    stub_st <= 3'b000; stub_res <= alu_calc(alu_op, alu_a, alu_b); stub_fresh <= 1'b1;
                end
                3'b011, 3'b100: begin
                    stub_cnt <= stub_cnt + 2'd1;
                    if (stub_cnt == 2'd1) stub_st <= 3'b101;
                end
                3'b101: begin
                    stub_st <= 3'b000; stub_res <= alu_calc(alu_op, alu_a, alu_b); stub_fresh <= 1'b1;
                end
                default: stub_st <= 3'b000;
            endcase
        end
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic push_cmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, output bit ok);
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        for (int i = 0; i < 200; i++) begin
            if (cmd_ready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    // Waits for res_valid at negedges; reports latency from the alu_start
    // sample, the number of start samples, the ALU state one sample before
    // the result, and whether operands held the given values while waiting.
    task automatic wait_result(input logic [7:0] ea, input logic [7:0] eb,
                               output bit ok, output logic [15:0] data, output logic [1:0] op,
                               output logic err, output int lat, output int starts,
                               output logic [2:0] prev_st, output bit stable);
        int start_at;
        logic [2:0] prev;
        ok = 1'b0; data = '0; op = '0; err = 1'b0; lat = -1; starts = 0;
        prev_st = 3'b111; stable = 1'b1; start_at = 0; prev = alu_state;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (alu_start) begin starts++; start_at = c; end
            if (res_valid) begin
                ok = 1'b1; data = res_data; op = res_op; err = res_err;
                lat = c - start_at; prev_st = prev;
                break;
            end
            if (starts > 0 && (alu_a !== ea || alu_b !== eb)) stable = 1'b0;
            prev = alu_state;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; res_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); else n_pass++;
        n_checks++;
        if ({res_valid, res_err, alu_start} !== 3'b000)
            $display("FAIL reset_flags got valid=%b err=%b start=%b exp=000", res_valid, res_err, alu_start);
        else n_pass++;
        n_checks++;
        if ({res_data, res_op, alu_op, alu_a, alu_b} !== 36'h0)
            $display("FAIL reset_data got res=%h op=%b aop=%b a=%h b=%h exp=0", res_data, res_op, alu_op, alu_a, alu_b);
        else n_pass++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({res_valid, alu_start} !== 2'b00) $display("FAIL idle_after_reset got valid=%b start=%b exp=00", res_valid, alu_start);
        else n_pass++;
    endtask

    task automatic test_add();
        bit ok, stable; logic [15:0] d; logic [1:0] o; logic e; int lat, starts; logic [2:0] pst;
        res_ready = 1'b1;
        push_cmd(2'b00, 8'd5, 8'd3, ok);
        wait_result(8'd5, 8'd3, ok, d, o, e, lat, starts, pst, stable);
        n_checks++;
        if (!ok) $display("FAIL add_timeout got=no_result exp=result"); else n_pass++;
        n_checks++;
        if (d !== 16'h0008 || o !== 2'b00 || e !== 1'b0)
            $display("FAIL add_result got data=%h op=%b err=%b exp data=0008 op=00 err=0", d, o, e);
        else n_pass++;
        n_checks++;
        if (lat !== 3) $display("FAIL add_latency got=%0d exp=3", lat); else n_pass++;
        n_checks++;
        if (starts !== 1) $display("FAIL add_start_width got=%0d exp=1", starts); else n_pass++;
        n_checks++;
        if (pst !== 3'b000) $display("FAIL add_capture_point got state=%b exp=000", pst); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0) $display("FAIL add_valid_clear got=%b exp=0", res_valid); else n_pass++;
    endtask

    task automatic test_sub_ovf();
        bit ok, stable; logic [15:0] d; logic [1:0] o; logic e; int lat, starts; logic [2:0] pst;
        push_cmd(2'b01, 8'd3, 8'd5, ok);
        wait_result(8'd3, 8'd5, ok, d, o, e, lat, starts, pst, stable);
        n_checks++;
        if (!ok || d !== 16'hFFFE || o !== 2'b01)
            $display("FAIL sub_result got ok=%0d data=%h op=%b exp data=fffe op=01", ok, d, o);
        else n_pass++;
        n_checks++;
        if (!stable) $display("FAIL sub_operands_stable got=changed exp=stable"); else n_pass++;
        push_cmd(2'b00, 8'h80, 8'h80, ok);
        wait_result(8'h80, 8'h80, ok, d, o, e, lat, starts, pst, stable);
        n_checks++;
        if (!ok || d !== 16'hFF00 || o !== 2'b00)
            $display("FAIL add_neg_result got ok=%0d data=%h op=%b exp data=ff00 op=00", ok, d, o);
        else n_pass++;
        n_checks++;
        if (!stable || alu_a !== 8'h80 || alu_b !== 8'h80)
            $display("FAIL add_neg_operands got a=%h b=%h stable=%0d exp a=80 b=80 stable=1", alu_a, alu_b, stable);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int st_t[$]; int vl_t[$]; logic [15:0] d[$]; logic [1:0] o[$]; logic [2:0] pst[$];
        logic [2:0] prev; bit ok1, ok2;
        res_ready = 1'b1;
        push_cmd(2'b10, 8'hFD, 8'd4, ok1);
        push_cmd(2'b11, 8'd100, 8'd7, ok2);
        prev = alu_state;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (alu_start) st_t.push_back(c);
            if (res_valid) begin
                vl_t.push_back(c); d.push_back(res_data); o.push_back(res_op); pst.push_back(prev);
            end
            prev = alu_state;
        end
        n_checks++;
        if (!(ok1 && ok2) || st_t.size() != 2 || vl_t.size() != 2)
            $display("FAIL b2b_counts got starts=%0d results=%0d exp starts=2 results=2", st_t.size(), vl_t.size());
        else begin
            n_pass++;
            n_checks++;
            if (d[0] !== 16'hFFF4 || o[0] !== 2'b10)
                $display("FAIL b2b_mul got data=%h op=%b exp data=fff4 op=10", d[0], o[0]);
            else n_pass++;
            n_checks++;
            if (d[1] !== 16'h000E || o[1] !== 2'b11)
                $display("FAIL b2b_div got data=%h op=%b exp data=000e op=11", d[1], o[1]);
            else n_pass++;
            n_checks++;
            if (vl_t[0] - st_t[0] != 5 || vl_t[1] - st_t[1] != 5)
                $display("FAIL b2b_latency got mul=%0d div=%0d exp 5 and 5", vl_t[0] - st_t[0], vl_t[1] - st_t[1]);
            else n_pass++;
            n_checks++;
            if (st_t[1] - vl_t[0] != 2)
                $display("FAIL b2b_reissue got gap=%0d exp=2", st_t[1] - vl_t[0]);
            else n_pass++;
            n_checks++;
            if (pst[0] !== 3'b000 || pst[1] !== 3'b000)
                $display("FAIL b2b_capture_point got %b,%b exp 000,000", pst[0], pst[1]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [1:0]  ops [6] = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b00};
        logic [7:0]  as_ [6] = '{8'd1, 8'd10, 8'd7, 8'd0, 8'd5, 8'd100};
        logic [7:0]  bs_ [6] = '{8'd2, 8'd4, 8'd7, 8'd1, 8'd5, 8'd27};
        logic [15:0] exp_d [6] = '{16'h0003, 16'h0006, 16'h000E, 16'hFFFF, 16'h0019, 16'h007F};
        logic [15:0] got_d[$]; logic [1:0] got_o[$];
        bit ok, all_ok, refused, drop;
        res_ready = 1'b0;
        all_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push_cmd(ops[i], as_[i], bs_[i], ok);
            all_ok = all_ok && ok;
        end
        repeat (12) @(negedge clk);
        n_checks++;
        if (!all_ok || res_valid !== 1'b1 || res_data !== 16'h0003 || cmd_ready !== 1'b0)
            $display("FAIL bp_held got pushed=%0d valid=%b data=%h ready=%b exp 1 1 0003 0",
                     all_ok, res_valid, res_data, cmd_ready);
        else n_pass++;
        cmd_valid = 1'b1; cmd_op = ops[5]; cmd_a = as_[5]; cmd_b = bs_[5];
        refused = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (cmd_ready !== 1'b0) refused = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!refused) $display("FAIL bp_sixth_refused got=accepted exp=refused"); else n_pass++;
        res_ready = 1'b1;
        drop = 1'b0;
        for (int c = 0; c < 150 && got_d.size() < 6; c++) begin
            if (res_valid && res_ready) begin got_d.push_back(res_data); got_o.push_back(res_op); end
            if (cmd_valid && cmd_ready) drop = 1'b1;
            @(posedge clk); #1;
            if (drop) cmd_valid = 1'b0;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (got_d.size() != 6) $display("FAIL bp_count got=%0d exp=6", got_d.size());
        else begin
            n_pass++;
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (got_d[i] !== exp_d[i] || got_o[i] !== ops[i])
                    $display("FAIL bp_order[%0d] got data=%h op=%b exp data=%h op=%b", i, got_d[i], got_o[i], exp_d[i], ops[i]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_midop();
        bit ok1, ok2, ok, stable, seen, spurious; logic [15:0] d; logic [1:0] o; logic e;
        int lat, starts; logic [2:0] pst;
        res_ready = 1'b1;
        push_cmd(2'b10, 8'd7, 8'd9, ok1);
        push_cmd(2'b00, 8'd9, 8'd9, ok2);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (alu_start) begin seen = 1'b1; break; end
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if (!(ok1 && ok2 && seen) || res_valid !== 1'b0 || alu_start !== 1'b0 || cmd_ready !== 1'b1 ||
            {res_data, res_op, res_err, alu_op, alu_a, alu_b} !== 37'h0)
            $display("FAIL midop_reset_values got valid=%b start=%b ready=%b res=%h aop=%b a=%h b=%h exp reset",
                     res_valid, alu_start, cmd_ready, res_data, alu_op, alu_a, alu_b);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        spurious = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (res_valid || alu_start) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) $display("FAIL midop_no_result got=activity exp=none"); else n_pass++;
        push_cmd(2'b00, 8'd1, 8'd1, ok);
        wait_result(8'd1, 8'd1, ok, d, o, e, lat, starts, pst, stable);
        n_checks++;
        if (!ok || d !== 16'h0002 || o !== 2'b00)
            $display("FAIL midop_followup got ok=%0d data=%h op=%b exp data=0002 op=00", ok, d, o);
        else n_pass++;
        spurious = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (res_valid) spurious = 1'b1;
        end
        n_checks++;
        if (spurious) $display("FAIL midop_fifo_discard got=extra_result exp=none"); else n_pass++;
    endtask

`ifdef ALU_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, got, seen, stable; logic [15:0] d; logic [1:0] o; logic e;
        int cyc, lat, starts; logic [2:0] pst;
        res_ready = 1'b1;
        push_cmd(2'b10, 8'd6, 8'd6, ok);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (alu_start) begin seen = 1'b1; break; end
        end
        stub_stuck = 1'b1;
        got = 1'b0; cyc = 0; d = '0; o = '0; e = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (res_valid) begin got = 1'b1; cyc = c; d = res_data; o = res_op; e = res_err; break; end
        end
        n_checks++;
        if (!(ok && seen && got) || e !== 1'b1 || d !== 16'h0000 || o !== 2'b10)
            $display("FAIL timeout_result got got=%0d err=%b data=%h op=%b exp err=1 data=0000 op=10", got, e, d, o);
        else n_pass++;
        n_checks++;
        if (cyc != TIMEOUT_CYCLES + 1) $display("FAIL timeout_latency got=%0d exp=%0d", cyc, TIMEOUT_CYCLES + 1);
        else n_pass++;
        push_cmd(2'b00, 8'd2, 8'd2, ok);
        starts = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (alu_start) starts++;
        end
        n_checks++;
        if (starts != 0) $display("FAIL timeout_gate got starts=%0d exp=0", starts); else n_pass++;
        stub_stuck = 1'b0;
        wait_result(8'd2, 8'd2, ok, d, o, e, lat, starts, pst, stable);
        n_checks++;
        if (!ok || d !== 16'h0004 || e !== 1'b0)
            $display("FAIL timeout_recover got ok=%0d data=%h err=%b exp data=0004 err=0", ok, d, e);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub_ovf();
        test_back_to_back();
        test_backpressure();
        test_reset_midop();
`ifdef ALU_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=hung exp=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
